// File: rtl/seq_alu_if.sv
// Bus bundle for the multi-cycle ALU: request operands in, result and flags out.
// The master drives the request; the ALU is the slave.
interface seq_alu_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic [2:0]       cntrl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             negative;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output start, cntrl, A, B,
    input  busy, done, result,
    input  negative, zero, overflow, carry_out
  );

  modport slave (
    input  start, cntrl, A, B,
    output busy, done, result,
    output negative, zero, overflow, carry_out
  );
endinterface

// File: rtl/seq_alu.sv
// Multi-cycle ALU: one CHUNK-wide slice reused WIDTH/CHUNK times, LS chunk first.
// Operands shift right past the slice; finished chunks shift into a shadow register.
module seq_alu #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic    clk,
  input  logic    reset,
  seq_alu_if.slave bus
);
  localparam int N  = WIDTH / CHUNK;
  localparam int KW = $clog2(N + 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_alu: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [KW-1:0]    k_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic             c_q;
  logic             zacc_q;
  logic [WIDTH-1:0] res_q;
  logic             neg_q;
  logic             zero_q;
  logic             ovf_q;
  logic             cout_q;
  logic             done_q;

  logic [CHUNK-1:0] a_c;
  logic [CHUNK-1:0] b_c;
  logic [CHUNK-1:0] bx_c;
  logic [CHUNK-1:0] r_c;
  logic [CHUNK:0]   sum_c;
  logic             cmsb_c;
  logic             arith;
  logic             last;
  logic             zacc_d;
  logic [WIDTH-1:0] full_d;

  assign a_c    = a_q[CHUNK-1:0];
  assign b_c    = b_q[CHUNK-1:0];
  assign arith  = (op_q[2:1] == 2'b01);
  assign bx_c   = op_q[0] ? ~b_c : b_c;
  assign sum_c  = {1'b0, a_c} + {1'b0, bx_c}
                + {{CHUNK{1'b0}}, c_q};
  assign cmsb_c = a_c[CHUNK-1] ^ bx_c[CHUNK-1]
                ^ sum_c[CHUNK-1];
  assign last   = (k_q == KW'(N - 1));
  assign zacc_d = zacc_q & (r_c == '0);

  always_comb begin
    r_c = '0;
    unique case (op_q)
      3'b000:  r_c = b_c;
      3'b010:  r_c = sum_c[CHUNK-1:0];
      3'b011:  r_c = sum_c[CHUNK-1:0];
      3'b100:  r_c = a_c & b_c;
      3'b101:  r_c = a_c | b_c;
      3'b110:  r_c = a_c ^ b_c;
      default: r_c = '0;
    endcase
  end

  // Shadow holds the chunks finished so far; the last chunk joins on top.
  if (N > 1) begin : g_shadow
    logic [WIDTH-CHUNK-1:0] sh_q;
    always_ff @(posedge clk) begin
      if (reset) begin
        sh_q <= '0;
      end else if (state_q == RUN) begin
        sh_q <= full_d[WIDTH-1:CHUNK];
      end
    end
    assign full_d = {r_c, sh_q};
  end else begin : g_single
    assign full_d = r_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      c_q     <= 1'b0;
      zacc_q  <= 1'b1;
      res_q   <= '0;
      neg_q   <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      cout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            op_q    <= bus.cntrl;
            c_q     <= (bus.cntrl[2:1] == 2'b01)
                     & bus.cntrl[0];
            k_q     <= '0;
            zacc_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          a_q    <= a_q >> CHUNK;
          b_q    <= b_q >> CHUNK;
          c_q    <= arith & sum_c[CHUNK];
          zacc_q <= zacc_d;
          k_q    <= k_q + KW'(1);
          if (last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            res_q   <= full_d;
            neg_q   <= r_c[CHUNK-1];
            zero_q  <= zacc_d;
            ovf_q   <= arith & (cmsb_c ^ sum_c[CHUNK]);
            cout_q  <= arith & sum_c[CHUNK];
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.result    = res_q;
  assign bus.negative  = neg_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;
endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: CHUNK=8 and CHUNK=64 instances share one stimulus stream
// and are compared every cycle against a full-width latency/arithmetic model.
module tb_seq_alu;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  cntrl;
  logic [63:0] A;
  logic [63:0] B;

  int errors = 0;
  int checks = 0;
  int ecnt   = 0;

  always #5 clk = ~clk;

  seq_alu_if #(.WIDTH(64)) if0 ();
  seq_alu_if #(.WIDTH(64)) if1 ();

  seq_alu #(.WIDTH(64), .CHUNK(8)) dut0 (
    .clk(clk), .reset(rst), .bus(if0)
  );
  seq_alu #(.WIDTH(64), .CHUNK(64)) dut1 (
    .clk(clk), .reset(rst), .bus(if1)
  );

  assign if0.start = start;
  assign if0.cntrl = cntrl;
  assign if0.A     = A;
  assign if0.B     = B;
  assign if1.start = start;
  assign if1.cntrl = cntrl;
  assign if1.A     = A;
  assign if1.B     = B;

  logic        busy_w [2];
  logic        done_w [2];
  logic        n_w    [2];
  logic        z_w    [2];
  logic        v_w    [2];
  logic        c_w    [2];
  logic [63:0] res_w  [2];

  assign busy_w[0] = if0.busy;
  assign done_w[0] = if0.done;
  assign n_w[0]    = if0.negative;
  assign z_w[0]    = if0.zero;
  assign v_w[0]    = if0.overflow;
  assign c_w[0]    = if0.carry_out;
  assign res_w[0]  = if0.result;
  assign busy_w[1] = if1.busy;
  assign done_w[1] = if1.done;
  assign n_w[1]    = if1.negative;
  assign z_w[1]    = if1.zero;
  assign v_w[1]    = if1.overflow;
  assign c_w[1]    = if1.carry_out;
  assign res_w[1]  = if1.result;

  typedef struct packed {
    logic [63:0] r;
    logic        n;
    logic        z;
    logic        v;
    logic        c;
  } res_t;

  function automatic res_t ref_alu(input logic [2:0] op,
                                   input logic [63:0] a,
                                   input logic [63:0] b);
    res_t o;
    logic [64:0] s;
    o = '0;
    s = '0;
    case (op)
      3'b000: o.r = b;
      3'b010: begin
        s   = {1'b0, a} + {1'b0, b};
        o.r = s[63:0];
        o.c = s[64];
        o.v = (a[63] == b[63]) && (o.r[63] != a[63]);
      end
      3'b011: begin
        s   = {1'b0, a} + {1'b0, ~b} + 65'd1;
        o.r = s[63:0];
        o.c = s[64];
        o.v = (a[63] != b[63]) && (o.r[63] != a[63]);
      end
      3'b100: o.r = a & b;
      3'b101: o.r = a | b;
      3'b110: o.r = a ^ b;
      default: o.r = '0;
    endcase
    o.n = o.r[63];
    o.z = (o.r == 64'd0);
    return o;
  endfunction

  function automatic int nch(input int i);
    return (i == 0) ? 8 : 1;
  endfunction

  // Model: an accepted op finishes N edges later; busy while pending.
  logic pend     [2];
  int   tdone    [2];
  res_t nxt      [2];
  res_t expv     [2];
  logic exp_done [2];

  always @(posedge clk) begin
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        pend[i]     = 1'b0;
        exp_done[i] = 1'b0;
        expv[i]     = '{r: 64'd0, n: 1'b0, z: 1'b1,
                        v: 1'b0, c: 1'b0};
      end else begin
        logic acc;
        acc         = !pend[i] && start;
        exp_done[i] = 1'b0;
        if (pend[i] && ecnt == tdone[i]) begin
          pend[i]     = 1'b0;
          expv[i]     = nxt[i];
          exp_done[i] = 1'b1;
        end
        if (acc) begin
          pend[i]  = 1'b1;
          tdone[i] = ecnt + nch(i);
          nxt[i]   = ref_alu(cntrl, A, B);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ecnt > 0) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("m%0d busy", i), 64'(busy_w[i]), 64'(pend[i]));
        chk($sformatf("m%0d done", i), 64'(done_w[i]), 64'(exp_done[i]));
        chk($sformatf("m%0d result", i), res_w[i], expv[i].r);
        chk($sformatf("m%0d neg", i), 64'(n_w[i]), 64'(expv[i].n));
        chk($sformatf("m%0d zero", i), 64'(z_w[i]), 64'(expv[i].z));
        chk($sformatf("m%0d ovf", i), 64'(v_w[i]), 64'(expv[i].v));
        chk($sformatf("m%0d cout", i), 64'(c_w[i]), 64'(expv[i].c));
      end
    end
  end

  task automatic launch(input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b);
    @(negedge clk);
    start = 1'b1;
    cntrl = op;
    A     = a;
    B     = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int idx, input string nm,
                           input int cyc);
    int t0;
    t0 = ecnt;
    while (!done_w[idx] && (ecnt - t0) < 40) @(negedge clk);
    chk({nm, " cycles"}, 64'(ecnt - t0 + 1), 64'(cyc));
  endtask

  task automatic check_out(input int idx, input string nm,
                           input logic [63:0] r, input logic n,
                           input logic z, input logic v,
                           input logic c);
    chk({nm, " result"}, res_w[idx], r);
    chk({nm, " neg"},  64'(n_w[idx]), 64'(n));
    chk({nm, " zero"}, 64'(z_w[idx]), 64'(z));
    chk({nm, " ovf"},  64'(v_w[idx]), 64'(v));
    chk({nm, " cout"}, 64'(c_w[idx]), 64'(c));
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 4))
      0: return 64'd0;
      1: return 64'hFFFF_FFFF_FFFF_FFFF;
      2: return 64'h7FFF_FFFF_FFFF_FFFF;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   t0;
    rst   = 1'b1;
    start = 1'b0;
    cntrl = 3'd0;
    A     = 64'd0;
    B     = 64'd0;
    repeat (2) @(negedge clk);
    check_out(0, "reset", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("reset busy", 64'(busy_w[0]), 64'd0);
    chk("reset done", 64'(done_w[0]), 64'd0);
    rst = 1'b0;

    launch(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    wait_done(0, "add_ovf", 9);
    check_out(0, "add_ovf", 64'h8000_0000_0000_0000,
              1'b1, 1'b0, 1'b1, 1'b0);

    launch(3'b011, 64'd5, 64'd5);
    wait_done(0, "sub_eq", 9);
    check_out(0, "sub_eq", 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    launch(3'b011, 64'd0, 64'd1);
    wait_done(0, "sub_neg", 9);
    check_out(0, "sub_neg", 64'hFFFF_FFFF_FFFF_FFFF,
              1'b1, 1'b0, 1'b0, 1'b0);

    launch(3'b100, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    wait_done(0, "and", 9);
    check_out(0, "and", 64'hF000_F000_F000_F000,
              1'b1, 1'b0, 1'b0, 1'b0);

    launch(3'b101, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    wait_done(0, "or", 9);
    check_out(0, "or", 64'hFFF0_FFF0_FFF0_FFF0,
              1'b1, 1'b0, 1'b0, 1'b0);

    launch(3'b110, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00);
    wait_done(0, "xor", 9);
    check_out(0, "xor", 64'h0FF0_0FF0_0FF0_0FF0,
              1'b0, 1'b0, 1'b0, 1'b0);

    launch(3'b000, 64'h1234_0000_0000_0001, 64'd0);
    wait_done(0, "pass0", 9);
    check_out(0, "pass0", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    launch(3'b111, 64'h1, 64'h2);
    wait_done(0, "op111", 9);
    check_out(0, "op111", 64'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    launch(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
    wait_done(1, "c64", 2);
    check_out(1, "c64", 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    repeat (10) @(negedge clk);

    // Restarts while busy are dropped; a start in the DONE cycle is taken.
    launch(3'b010, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    t0 = ecnt;
    for (int j = 0; j < 7; j++) begin
      @(negedge clk);
      start = 1'b1;
      cntrl = 3'($urandom);
      A     = {$urandom, $urandom};
      B     = {$urandom, $urandom};
    end
    @(negedge clk);
    chk("ignore done", 64'(done_w[0]), 64'd1);
    chk("ignore cycles", 64'(ecnt - t0 + 1), 64'd9);
    check_out(0, "ignore", 64'h1234_5678_9ABC_DF00,
              1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    cntrl = 3'b011;
    A     = 64'd5;
    B     = 64'd5;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, "b2b", 9);
    check_out(0, "b2b", 64'd0, 1'b0, 1'b1, 1'b0, 1'b1);

    launch(3'b101, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F);
    wait_done(0, "pre_rst", 9);
    launch(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst busy", 64'(busy_w[0]), 64'd0);
    chk("rst done", 64'(done_w[0]), 64'd0);
    chk("rst result", res_w[0], 64'd0);
    chk("rst zero", 64'(z_w[0]), 64'd1);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (done_w[0]) seen = 1'b1;
    end
    chk("rst no done", 64'(seen), 64'd0);

    for (int j = 0; j < 500; j++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      cntrl = 3'($urandom);
      A     = pick();
      B     = pick();
      rst   = ($urandom_range(0, 79) == 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    repeat (15) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
